// File: rtl/full_adder.sv
// Ripple-carry adder built from explicit 1-bit full-adder cells, with an
// optional output register stage cleared by an asynchronous active-low reset.
module full_adder #(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0]   carry_p0;
    logic [WIDTH-1:0] sum_p0;

    assign carry_p0[0] = cin;

    // Stage p0: one full-adder cell per bit, carry rippling from LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum_p0[i]     = a[i] ^ b[i] ^ carry_p0[i];
        assign carry_p0[i+1] = (a[i] & b[i]) | (a[i] & carry_p0[i]) | (b[i] & carry_p0[i]);
    end

    if (REGISTERED) begin : g_reg
        // Stage p1: capture the cell outputs; reset clears them without a clock edge.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                sum  <= '0;
                cout <= 1'b0;
            end else begin
                sum  <= sum_p0;
                cout <= carry_p0[WIDTH];
            end
        end
    end else begin : g_comb
        // Clock and reset have no role when the adder is purely combinational.
        logic unused_clock_reset;
        assign unused_clock_reset = clock & reset_n;
        assign sum  = sum_p0;
        assign cout = carry_p0[WIDTH];
    end

endmodule

// File: tb/tb_full_adder.sv
// Randomized self-checking bench for full_adder: registered 1/8/64-bit adders
// and a combinational 4-bit adder compared against plain integer addition.
module tb_full_adder;

    logic clock;
    logic reset_n;

    logic        a1, b1, c1, sum1, cout1;
    logic [7:0]  a8, b8, sum8;
    logic        c8, cout8;
    logic [63:0] a64, b64, sum64;
    logic        c64, cout64;
    logic [3:0]  a4, b4, sum4;
    logic        c4, cout4;

    int n_checks;
    int n_fail;

    full_adder #(.WIDTH(1), .REGISTERED(1'b1)) u_w1 (
        .clock(clock), .reset_n(reset_n), .a(a1), .b(b1), .cin(c1), .sum(sum1), .cout(cout1)
    );
    full_adder #(.WIDTH(8), .REGISTERED(1'b1)) u_w8 (
        .clock(clock), .reset_n(reset_n), .a(a8), .b(b8), .cin(c8), .sum(sum8), .cout(cout8)
    );
    full_adder #(.WIDTH(64), .REGISTERED(1'b1)) u_w64 (
        .clock(clock), .reset_n(reset_n), .a(a64), .b(b64), .cin(c64), .sum(sum64), .cout(cout64)
    );
    full_adder #(.WIDTH(4), .REGISTERED(1'b0)) u_w4c (
        .clock(clock), .reset_n(reset_n), .a(a4), .b(b4), .cin(c4), .sum(sum4), .cout(cout4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        reset_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a8 = 8'hA5; b8 = 8'h7E; c8 = 1'b1;
        a64 = 64'hFFFF_0000_1234_5678; b64 = 64'h0F0F_F0F0_0000_FFFF; c64 = 1'b1;
        a4 = 4'h3; b4 = 4'h4; c4 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({cout1, sum1} !== 2'b00) begin
            n_fail++; $display("FAIL reset_w1: got %b, expected 00", {cout1, sum1});
        end
        n_checks++;
        if ({cout8, sum8} !== 9'h000) begin
            n_fail++; $display("FAIL reset_w8: got %h, expected 000", {cout8, sum8});
        end
        n_checks++;
        if ({cout64, sum64} !== 65'h0) begin
            n_fail++; $display("FAIL reset_w64: got %h, expected 0", {cout64, sum64});
        end
        n_checks++;
        if ({cout4, sum4} !== 5'h07) begin
            n_fail++; $display("FAIL reset_comb_w4: got %h, expected 07", {cout4, sum4});
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_sequence();
        logic [2:0] vec [4];
        logic [1:0] exp [4];
        vec = '{3'b100, 3'b101, 3'b111, 3'b011};
        exp = '{2'b01, 2'b10, 2'b11, 2'b10};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            a1 = vec[i][2]; b1 = vec[i][1]; c1 = vec[i][0];
            @(posedge clock);
            #1;
            n_checks++;
            if ({cout1, sum1} !== exp[i]) begin
                n_fail++; $display("FAIL sequence_%0d: got cout/sum %b, expected %b", i, {cout1, sum1}, exp[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [1:0] prev;
        logic [2:0] k;
        int t;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            prev = {cout1, sum1};
            k = 3'(i);
            a1 = k[2]; b1 = k[1]; c1 = k[0];
            t = int'(k[2]) + int'(k[1]) + int'(k[0]);
            #1;
            n_checks++;
            if ({cout1, sum1} !== prev) begin
                n_fail++; $display("FAIL exhaustive_hold_%0d: got %b, expected %b", i, {cout1, sum1}, prev);
            end
            @(posedge clock);
            #1;
            n_checks++;
            if ({cout1, sum1} !== 2'(t)) begin
                n_fail++; $display("FAIL exhaustive_%0d: got %b, expected %b", i, {cout1, sum1}, 2'(t));
            end
        end
    endtask

    task automatic test_width8();
        @(negedge clock);
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if ({cout8, sum8} !== 9'h100) begin
            n_fail++; $display("FAIL w8_wrap: got %h, expected 100", {cout8, sum8});
        end
        @(negedge clock);
        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
        @(posedge clock);
        #1;
        n_checks++;
        if ({cout8, sum8} !== 9'h080) begin
            n_fail++; $display("FAIL w8_carry_chain: got %h, expected 080", {cout8, sum8});
        end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a8 = 8'h80; b8 = 8'h80; c8 = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if ({cout1, sum1} !== 2'b11) begin
            n_fail++; $display("FAIL async_preload: got %b, expected 11", {cout1, sum1});
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({cout1, sum1} !== 2'b00) begin
            n_fail++; $display("FAIL async_clear_w1: got %b, expected 00", {cout1, sum1});
        end
        n_checks++;
        if ({cout8, sum8} !== 9'h000) begin
            n_fail++; $display("FAIL async_clear_w8: got %h, expected 000", {cout8, sum8});
        end
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        @(posedge clock);
        #1;
        n_checks++;
        if ({cout1, sum1} !== 2'b00) begin
            n_fail++; $display("FAIL async_hold_low: got %b, expected 00", {cout1, sum1});
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if ({cout1, sum1} !== 2'b10) begin
            n_fail++; $display("FAIL async_first_capture: got %b, expected 10", {cout1, sum1});
        end
    endtask

    task automatic test_comb();
        @(posedge clock);
        #1;
        a4 = 4'h9; b4 = 4'h8; c4 = 1'b1;
        #1;
        n_checks++;
        if ({cout4, sum4} !== 5'h12) begin
            n_fail++; $display("FAIL comb_w4: got %h, expected 12", {cout4, sum4});
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  e1, p1;
        logic [8:0]  e8, p8;
        logic [64:0] e64, p64;
        logic [4:0]  e4;
        int mode;
        p1 = {cout1, sum1}; p8 = {cout8, sum8}; p64 = {cout64, sum64};
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            mode = int'($urandom_range(0, 5));
            if (mode == 0) begin
                a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
                a8 = '1; b8 = '1; c8 = 1'b1;
                a64 = '1; b64 = '1; c64 = 1'b1;
                a4 = '1; b4 = '1; c4 = 1'b1;
            end else if (mode == 1) begin
                a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
                a8 = '0; b8 = '0; c8 = 1'b0;
                a64 = '0; b64 = '0; c64 = 1'b0;
                a4 = '0; b4 = '0; c4 = 1'b0;
            end else begin
                a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
                a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
                a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; c64 = 1'($urandom);
                a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
            end
            e1  = 2'(a1) + 2'(b1) + 2'(c1);
            e8  = 9'(a8) + 9'(b8) + 9'(c8);
            e64 = 65'(a64) + 65'(b64) + 65'(c64);
            e4  = 5'(a4) + 5'(b4) + 5'(c4);
            #1;
            n_checks++;
            if ({cout4, sum4} !== e4) begin
                n_fail++; $display("FAIL rand_comb_w4_%0d: got %h, expected %h", n, {cout4, sum4}, e4);
            end
            n_checks++;
            if ({cout1, sum1} !== p1) begin
                n_fail++; $display("FAIL rand_hold_w1_%0d: got %b, expected %b", n, {cout1, sum1}, p1);
            end
            n_checks++;
            if ({cout8, sum8} !== p8) begin
                n_fail++; $display("FAIL rand_hold_w8_%0d: got %h, expected %h", n, {cout8, sum8}, p8);
            end
            n_checks++;
            if ({cout64, sum64} !== p64) begin
                n_fail++; $display("FAIL rand_hold_w64_%0d: got %h, expected %h", n, {cout64, sum64}, p64);
            end
            @(posedge clock);
            #1;
            n_checks++;
            if ({cout1, sum1} !== e1) begin
                n_fail++; $display("FAIL rand_w1_%0d: got %b, expected %b", n, {cout1, sum1}, e1);
            end
            n_checks++;
            if ({cout8, sum8} !== e8) begin
                n_fail++; $display("FAIL rand_w8_%0d: got %h, expected %h", n, {cout8, sum8}, e8);
            end
            n_checks++;
            if ({cout64, sum64} !== e64) begin
                n_fail++; $display("FAIL rand_w64_%0d: got %h, expected %h", n, {cout64, sum64}, e64);
            end
            p1 = e1; p8 = e8; p64 = e64;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sequence();
        test_exhaustive();
        test_width8();
        test_async_reset();
        test_comb();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
Clocked ripple-carry full adder. It adds two WIDTH-bit operands plus a carry-in and produces a WIDTH-bit sum and a carry-out. Outputs are registered on the rising clock edge, so the block can sit directly in a pipelined datapath. The default WIDTH=1 gives the classic single-bit full adder cell used as a building block in wider arithmetic units.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.
- REGISTERED, 1, 1 = outputs registered (1-cycle latency); 0 = purely combinational outputs, with clock and reset_n unused.

Ports:
- clock  input  1  system clock; rising-edge active.
- reset_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Arithmetic:
  - Internal ripple chain c[0]=cin.
  - For each bit i: s[i]=a[i]^b[i]^c[i] and c[i+1]=(a[i]&b[i])|(a[i]&c[i])|(b[i]&c[i]).
  - cout=c[WIDTH].
  - Equivalent to {cout,sum} = a + b + cin, computed at WIDTH+1 bits.
- Implementation: use a generate loop of 1-bit cells, not a single "+" operator, so the cell structure is visible in synthesis.
- Timing with REGISTERED=1:
  - sum and cout update on each rising clock edge from the a, b and cin values present at that edge.
  - Latency is 1 cycle; throughput is 1 result per cycle; there is no enable or handshake.
  - Outputs hold between edges, and input changes between edges are not visible until the next edge.
- Timing with REGISTERED=0: sum and cout follow the inputs combinationally.
- Reset:
  - reset_n low forces sum=0 and cout=0 immediately, regardless of clock.
  - Outputs stay 0 while reset_n is low.
  - The first capture occurs on the first rising edge after reset_n deasserts.
- Boundary conditions:
  - All-ones operands with cin=1 give sum=all-ones and cout=1.
  - All-zeros inputs give sum=0 and cout=0.
  - Wrap-around is modulo 2^WIDTH, with the overflow reported only via cout.
- Unknown inputs: X or Z on a, b or cin may propagate X to the outputs; no X-suppression is required.
- Reset mid-operation: asserting reset_n between edges clears the outputs at once, and any in-flight result is discarded.

Test Plan:
- WIDTH=1, reset_n=0 → sum=0, cout=0 with the clock running; release reset_n before the first vector.
- WIDTH=1, sequence a/b/cin = 1/0/0, 1/0/1, 1/1/1, 0/1/1, each applied mid-cycle → after the next rising edge sum/cout = 1/0, 0/1, 1/1, 0/1.
- WIDTH=1, exhaustive 8 input combinations → outputs match a+b+cin one cycle later; outputs unchanged before that edge.
- WIDTH=8, a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1; then a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0.
- Assert reset_n low asynchronously mid-cycle while sum=1 → sum and cout drop to 0 without waiting for a clock edge; after release, the next edge captures the current inputs.
- REGISTERED=0, WIDTH=4, a=0x9, b=0x8, cin=1 → sum=0x2, cout=1 combinationally with no clock edge.
